// File: rtl/wb_rr_scheduler.sv
// Round-robin Wishbone scheduler: N masters share one slave with per-tenure ack quota.
// Optional stalled-strobe watchdog enabled by defining WB_SCHED_TIMEOUT_EN.
module wb_rr_scheduler #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned QUOTA     = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*AW-1:0] m_adr_i,
  input  logic [N_MASTERS*DW-1:0] m_dat_i,
  output logic [N_MASTERS*DW-1:0] m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic [N_MASTERS-1:0]    gnt_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i
);

  localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CW = $clog2(QUOTA + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] cand;
  logic          others_req;
  logic          hold;
  logic          timeout;
  logic          stb_c;
  logic          exit_c;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    return IW'((32'(base) + off) % N_MASTERS);
  endfunction

  // Cyclic scan starting just after the last granted master
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand = wrap_idx(last_q, i);
      if (!sel_found && m_cyc_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign others_req = |(m_cyc_i & ~gnt_q);
  assign hold       = (state_q == BUSY) && (cnt_q == CW'(QUOTA)) && others_req;

`ifdef WB_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_q, wdog_d;

  assign timeout = (state_q == BUSY) && (wdog_q == TW'(TIMEOUT));

  // Counts stalled strobe cycles within the current tenure
  always_comb begin
    wdog_d = wdog_q;
    if (state_q != BUSY || exit_c)  wdog_d = '0;
    else if (stb_c && s_ack_i)      wdog_d = '0;
    else if (stb_c)                 wdog_d = wdog_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exit_c = (state_q == BUSY) && (hold || !m_cyc_i[gidx_q] || timeout);

  // Next-state and tenure bookkeeping
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          gnt_d   = N_MASTERS'(1) << sel_idx;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (stb_c && s_ack_i && (cnt_q != CW'(QUOTA))) cnt_d = cnt_q + CW'(1);
        if (exit_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux and master-side ack/err steering
  always_comb begin
    stb_c   = 1'b0;
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == BUSY) begin
      stb_c            = m_stb_i[gidx_q] & ~hold & ~timeout;
      s_cyc_o          = m_cyc_i[gidx_q];
      s_we_o           = m_we_i[gidx_q];
      s_adr_o          = m_adr_i[32'(gidx_q)*AW +: AW];
      s_dat_o          = m_dat_i[32'(gidx_q)*DW +: DW];
      m_ack_o[gidx_q]  = s_ack_i & stb_c;
      m_err_o[gidx_q]  = timeout;
    end
  end

  assign s_stb_o = stb_c;
  assign m_dat_o = {N_MASTERS{s_dat_i}};
  assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_scheduler.sv
// Directed bench for wb_rr_scheduler: table-driven alternation trace plus
// hand-written single-master, preemption, watchdog and reset sequences.
module tb_wb_rr_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*DW-1:0] m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;

  int checks = 0;
  int errors = 0;

  wb_rr_scheduler #(.N_MASTERS(N), .AW(AW), .DW(DW), .QUOTA(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic [3:0] gnt;
    logic       scyc;
    logic       sstb;
    logic [3:0] mack;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic ack);
    @(negedge clk);
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = ack;
    #1;
  endtask

  task automatic chk_outs(input string name, input logic [3:0] gnt, input logic scyc,
                          input logic sstb, input logic [3:0] mack);
    chk({name, ".gnt"},  128'(gnt_o),   128'(gnt));
    chk({name, ".scyc"}, 128'(s_cyc_o), 128'(scyc));
    chk({name, ".sstb"}, 128'(s_stb_o), 128'(sstb));
    chk({name, ".mack"}, 128'(m_ack_o), 128'(mack));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int unsigned idx_of(input logic [3:0] oh);
    int unsigned r = 0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = k;
    return r;
  endfunction

  initial begin
    logic [3:0] ve = 4'b1010;
    rst     = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = 1'b0;
    m_we_i  = ve;
    s_dat_i = 32'hCAFE_0001;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW] = 32'h100 * (k + 1);
      m_dat_i[k*DW +: DW] = 32'hD0 + k;
    end

    // Two masters alternate under quota, one dead s_cyc cycle between tenures
    tbl[0]  = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 1; i <= 4; i++)
      tbl[i] = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};
    tbl[5]  = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 7; i <= 10; i++)
      tbl[i] = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100};
    tbl[11] = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000};
    tbl[12] = '{4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[13] = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001};

    // Reset state, with requests asserted while rst is held
    @(negedge clk);
    m_cyc_i = 4'b1111;
    @(negedge clk);
    #1;
    chk_outs("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("reset.err", 128'(m_err_o), 128'(0));
    chk("reset.adr", 128'(s_adr_o), 128'(0));

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].cyc, tbl[i].stb, tbl[i].ack);
      chk_outs($sformatf("alt[%0d]", i), tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].mack);
      if (tbl[i].scyc) begin
        chk($sformatf("alt[%0d].adr", i), 128'(s_adr_o), 128'(32'h100 * (idx_of(tbl[i].gnt) + 1)));
        chk($sformatf("alt[%0d].dat", i), 128'(s_dat_o), 128'(32'hD0 + idx_of(tbl[i].gnt)));
        chk($sformatf("alt[%0d].we", i),  128'(s_we_o),  128'(ve[idx_of(tbl[i].gnt)]));
      end else begin
        chk($sformatf("alt[%0d].adr0", i), 128'(s_adr_o), 128'(0));
      end
    end
    chk("bcast", m_dat_o, {4{32'hCAFE_0001}});

    // Single requester: ten back-to-back acks, never preempted
    do_reset();
    drive(4'b0010, 4'b0010, 1'b1);
    chk_outs("solo.idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      drive(4'b0010, 4'b0010, 1'b1);
      chk_outs($sformatf("solo[%0d]", i), 4'b0010, 1'b1, 1'b1, 4'b0010);
    end
    drive(4'b0000, 4'b0000, 1'b0);
    chk_outs("solo.drop", 4'b0010, 1'b0, 1'b0, 4'b0000);
    drive(4'b0000, 4'b0000, 1'b0);
    chk_outs("solo.idle2", 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Master 3 holds; master 0 joins at ack 2 and waits for quota
    do_reset();
    drive(4'b1000, 4'b1000, 1'b1);
    chk_outs("pre.idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
    drive(4'b1000, 4'b1000, 1'b1);
    chk_outs("pre.a1", 4'b1000, 1'b1, 1'b1, 4'b1000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.a2", 4'b1000, 1'b1, 1'b1, 4'b1000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.a3", 4'b1000, 1'b1, 1'b1, 4'b1000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.a4", 4'b1000, 1'b1, 1'b1, 4'b1000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.hold", 4'b1000, 1'b1, 1'b0, 4'b0000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.dead", 4'b0000, 1'b0, 1'b0, 4'b0000);
    drive(4'b1001, 4'b1001, 1'b1);
    chk_outs("pre.m0", 4'b0001, 1'b1, 1'b1, 4'b0001);

    // Slave never acks master 1 while master 2 waits
    do_reset();
    drive(4'b0110, 4'b0110, 1'b0);
    chk_outs("stall.idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
`ifdef WB_SCHED_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      drive(4'b0110, 4'b0110, 1'b0);
      chk_outs($sformatf("wd[%0d]", i), 4'b0010, 1'b1, 1'b1, 4'b0000);
      chk($sformatf("wd[%0d].err", i), 128'(m_err_o), 128'(0));
    end
    drive(4'b0110, 4'b0110, 1'b0);
    chk("wd.err", 128'(m_err_o), 128'(4'b0010));
    chk("wd.stb", 128'(s_stb_o), 128'(0));
    drive(4'b0110, 4'b0110, 1'b0);
    chk_outs("wd.dead", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("wd.err0", 128'(m_err_o), 128'(0));
    drive(4'b0110, 4'b0110, 1'b0);
    chk_outs("wd.next", 4'b0100, 1'b1, 1'b1, 4'b0000);
`else
    for (int i = 0; i < 110; i++) begin
      drive(4'b0110, 4'b0110, 1'b0);
      chk($sformatf("nowd[%0d].stb", i), 128'(s_stb_o), 128'(1));
      chk($sformatf("nowd[%0d].err", i), 128'(m_err_o), 128'(0));
    end
    chk("nowd.gnt", 128'(gnt_o), 128'(4'b0010));
`endif

    // Reset mid-tenure of master 2 at ack 2
    do_reset();
    drive(4'b0100, 4'b0100, 1'b1);
    drive(4'b0100, 4'b0100, 1'b1);
    chk_outs("rst.a1", 4'b0100, 1'b1, 1'b1, 4'b0100);
    drive(4'b0100, 4'b0100, 1'b1);
    chk_outs("rst.a2", 4'b0100, 1'b1, 1'b1, 4'b0100);
    rst = 1'b1;
    drive(4'b0101, 4'b0101, 1'b1);
    chk_outs("rst.after", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("rst.err", 128'(m_err_o), 128'(0));
    chk("rst.we",  128'(s_we_o),  128'(0));
    chk("rst.dat", 128'(s_dat_o), 128'(0));
    rst = 1'b0;
    drive(4'b0101, 4'b0101, 1'b1);
    chk_outs("rst.m0", 4'b0001, 1'b1, 1'b1, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_rr_scheduler.md
WB_RR_SCHEDULER -- requirements
Module: wb_rr_scheduler

Interface
REQ-001 Parameter N_MASTERS, default 4: number of Wishbone masters sharing one slave.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter QUOTA, default 4: max acked transfers per tenure when another master waits.
REQ-005 Parameter TIMEOUT, default 15: stalled-strobe cycles before abort.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 m_cyc_i  in  N_MASTERS  per-master cycle request.
REQ-009 m_stb_i  in  N_MASTERS  per-master strobe.
REQ-010 m_we_i  in  N_MASTERS  per-master write enable.
REQ-011 m_adr_i  in  N_MASTERS*AW  packed addresses, master k at [k*AW +: AW].
REQ-012 m_dat_i  in  N_MASTERS*DW  packed write data, same packing.
REQ-013 m_dat_o  out  N_MASTERS*DW  packed read data.
REQ-014 m_ack_o  out  N_MASTERS  per-master ack.
REQ-015 m_err_o  out  N_MASTERS  per-master timeout error.
REQ-016 gnt_o  out  N_MASTERS  one-hot current grant, registered.
REQ-017 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls.
REQ-018 s_adr_o  out  AW; s_dat_o  out  DW  slave address/write data.
REQ-019 s_dat_i  in  DW; s_ack_i  in  1  slave read data/ack.

Function
REQ-020 States IDLE, BUSY; IDLE with any m_cyc_i high SHALL select the first requester strictly after last_gnt (cyclic order), register gnt_o, enter BUSY next edge.
REQ-021 In BUSY, s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g] & ~hold, s_we_o/s_adr_o/s_dat_o = master g fields, combinationally; all zero in IDLE.
REQ-022 m_ack_o[g] = s_ack_i & s_stb_o; other acks 0; m_dat_o broadcasts s_dat_i to all slots.
REQ-023 Tenure counter SHALL count acks (saturating at QUOTA, width clog2(QUOTA+1)); cleared on entry to BUSY.
REQ-024 When count = QUOTA and any other m_cyc_i high, hold SHALL assert: no further strobe passes; BUSY -> IDLE next edge.
REQ-025 m_cyc_i[g] low in BUSY -> IDLE next edge; last_gnt <= g on every BUSY exit.
REQ-026 IDLE lasts exactly one cycle when requests pend (one dead s_cyc_o-low cycle between tenures).
REQ-027 Single requester: no quota preemption; tenure unbounded.
REQ-028 Preempted master keeps cyc high, receives no ack until re-granted; transfer not lost.
REQ-029 Request-to-first-s_stb_o latency: 1 cycle from IDLE.

Reset
REQ-030 On rst: state IDLE, gnt_o 0, last_gnt N_MASTERS-1 (master 0 served first), counters 0, m_ack_o/m_err_o 0, slave controls 0 from the cycle after rst sampled.
REQ-031 Reset mid-tenure SHALL abort it with no ack or err issued.

Configuration
REQ-032 Macro WB_SCHED_TIMEOUT_EN defined: watchdog counts cycles with s_stb_o high and s_ack_i low, clears on ack or BUSY exit; at count TIMEOUT, m_err_o[g] pulses one cycle, BUSY -> IDLE next edge.
REQ-033 Macro undefined: no watchdog logic, m_err_o tied 0, stalls wait indefinitely.

Verification
REQ-034 Masters 0,2 assert cyc/stb same cycle after reset, slave acks every cycle -> master 0 gets 4 acks, 1 dead cycle, master 2 gets 4 acks, repeat alternating.
REQ-035 Only master 1 requests 10 transfers -> 10 consecutive acks, gnt_o=0010 throughout, no dead cycle.
REQ-036 Master 3 holds, master 0 requests at ack 2 -> master 3 completes 4 acks, then gnt_o=0001 two edges later.
REQ-037 WB_SCHED_TIMEOUT_EN, slave never acks master 1 -> m_err_o[1] pulses after 15 strobe cycles, next requester granted; undefined: s_stb_o stays high 100+ cycles, m_err_o 0.
REQ-038 rst pulsed during master 2 tenure at ack 2 -> all outputs 0 next cycle, master 0 granted first afterwards.
